// File: rtl/foc_fixed_pkg.sv
// Shared fixed-point constants and sequencer state encoding for the FOC datapath.
// Q18 in 32-bit words is the default number format; K_SQRT3_2 is round(sqrt(3)/2 * 2^18).
package foc_fixed_pkg;

  localparam int FOC_N     = 32;
  localparam int FOC_Q     = 18;
  localparam int K_SQRT3_2 = 227023;

  typedef enum logic [2:0] {
    StIdle,
    StP0,
    StP1,
    StP2,
    StP3,
    StSum,
    StClk,
    StDone
  } pcs_state_e;

endpackage

// File: rtl/qmult.sv
// Signed Q-format multiplier: full-width product, arithmetic shift right by Q,
// truncated to N bits. o_ovf flags a shifted product that does not fit in N signed bits.
module qmult #(
  parameter int Q = 18,
  parameter int N = 32
) (
  input  logic signed [N-1:0] i_a,
  input  logic signed [N-1:0] i_b,
  output logic signed [N-1:0] o_result,
  output logic                o_ovf
);

  logic signed [2*N-1:0] w_full;
  logic signed [2*N-1:0] w_shift;

  // Full-precision product, rescaled back to Q fractional bits.
  always_comb begin
    w_full   = (2*N)'(i_a) * (2*N)'(i_b);
    w_shift  = w_full >>> Q;
    o_result = w_shift[N-1:0];
    // Every bit above the result sign must match it, otherwise the value was cut.
    o_ovf    = (w_shift[2*N-1:N-1] != {(N+1){w_shift[N-1]}});
  end

endmodule

// File: rtl/park_clark_sequencer.sv
// Inverse Park followed by inverse Clarke, time-multiplexed over one qmult.
// One transaction: P0..P3 form the four Park products, SUM forms ialpha/ibeta,
// CLK multiplies K*ibeta and forms ia/ib/ic, DONE settles one cycle then presents.
// Optional build macro PARK_CLARK_SAT_EN: saturate sum/difference results on overflow
// (default: two's-complement wrap). ovf is reported identically in both builds.
module park_clark_sequencer
  import foc_fixed_pkg::*;
#(
  parameter int N = FOC_N,
  parameter int Q = FOC_Q
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [N-1:0] id,
  input  logic signed [N-1:0] iq,
  input  logic signed [N-1:0] ctheta,
  input  logic signed [N-1:0] stheta,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [N-1:0] ialpha,
  output logic signed [N-1:0] ibeta,
  output logic signed [N-1:0] ia,
  output logic signed [N-1:0] ib,
  output logic signed [N-1:0] ic,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                ovf
);

  // Two guard bits cover every sum/difference formed here, including -K*ibeta - ialpha/2.
  localparam int W = N + 2;

  pcs_state_e r_state;

  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_ovf;
  logic signed [N-1:0] r_id;
  logic signed [N-1:0] r_iq;
  logic signed [N-1:0] r_ct;
  logic signed [N-1:0] r_st;
  logic signed [N-1:0] r_p0;
  logic signed [N-1:0] r_p1;
  logic signed [N-1:0] r_p2;
  logic signed [N-1:0] r_p3;
  logic signed [N-1:0] r_ialpha;
  logic signed [N-1:0] r_ibeta;
  logic signed [N-1:0] r_ia;
  logic signed [N-1:0] r_ib;
  logic signed [N-1:0] r_ic;

  logic signed [N-1:0] w_mul_a;
  logic signed [N-1:0] w_mul_b;
  logic signed [N-1:0] w_prod;
  logic                w_mul_ovf;

  logic signed [W-1:0] w_alpha_wide;
  logic signed [W-1:0] w_beta_wide;
  logic signed [W-1:0] w_ib_wide;
  logic signed [W-1:0] w_ic_wide;
  logic signed [N-1:0] w_half;
  logic signed [N-1:0] w_alpha;
  logic signed [N-1:0] w_beta;
  logic signed [N-1:0] w_ib;
  logic signed [N-1:0] w_ic;
  logic                w_alpha_ovf;
  logic                w_beta_ovf;
  logic                w_ib_ovf;
  logic                w_ic_ovf;

  // Reduce a guarded result to N bits: {overflow, value}, wrapped or saturated.
  function automatic logic [N:0] fit_n(input logic signed [W-1:0] x);
    logic          f_ovf;
    logic [N-1:0]  f_val;
    f_ovf = (x[W-1:N-1] != {3{x[N-1]}});
`ifdef PARK_CLARK_SAT_EN
    if (f_ovf) begin
      f_val = x[W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else begin
      f_val = x[N-1:0];
    end
`else
    f_val = x[N-1:0];
`endif
    return {f_ovf, f_val};
  endfunction

  // Steer the shared multiplier operands from the current state.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    unique case (r_state)
      StP0:    begin w_mul_a = r_ct; w_mul_b = r_id;    end
      StP1:    begin w_mul_a = r_st; w_mul_b = r_iq;    end
      StP2:    begin w_mul_a = r_st; w_mul_b = r_id;    end
      StP3:    begin w_mul_a = r_ct; w_mul_b = r_iq;    end
      StClk:   begin w_mul_a = N'(K_SQRT3_2); w_mul_b = r_ibeta; end
      default: begin w_mul_a = '0; w_mul_b = '0;       end
    endcase
  end

  qmult #(
    .Q (Q),
    .N (N)
  ) u_qmult (
    .i_a      (w_mul_a),
    .i_b      (w_mul_b),
    .o_result (w_prod),
    .o_ovf    (w_mul_ovf)
  );

  // Sum/difference network; ialpha/2 is a shift, never a multiplier pass.
  always_comb begin
    w_alpha_wide = W'(r_p0) - W'(r_p1);
    w_beta_wide  = W'(r_p2) + W'(r_p3);
    w_half       = r_ialpha >>> 1;
    w_ib_wide    = W'(w_prod) - W'(w_half);
    w_ic_wide    = -W'(w_prod) - W'(w_half);
    {w_alpha_ovf, w_alpha} = fit_n(w_alpha_wide);
    {w_beta_ovf, w_beta}   = fit_n(w_beta_wide);
    {w_ib_ovf, w_ib}       = fit_n(w_ib_wide);
    {w_ic_ovf, w_ic}       = fit_n(w_ic_wide);
  end

  // Sequencer FSM with all datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_ialpha    <= '0;
      r_ibeta     <= '0;
      r_ia        <= '0;
      r_ib        <= '0;
      r_ic        <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_id       <= id;
            r_iq       <= iq;
            r_ct       <= ctheta;
            r_st       <= stheta;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= StP0;
          end
        end
        StP0: begin
          r_p0    <= w_prod;
          r_ovf   <= r_ovf | w_mul_ovf;
          r_state <= StP1;
        end
        StP1: begin
          r_p1    <= w_prod;
          r_ovf   <= r_ovf | w_mul_ovf;
          r_state <= StP2;
        end
        StP2: begin
          r_p2    <= w_prod;
          r_ovf   <= r_ovf | w_mul_ovf;
          r_state <= StP3;
        end
        StP3: begin
          r_p3    <= w_prod;
          r_ovf   <= r_ovf | w_mul_ovf;
          r_state <= StSum;
        end
        StSum: begin
          r_ialpha <= w_alpha;
          r_ibeta  <= w_beta;
          r_ovf    <= r_ovf | w_alpha_ovf | w_beta_ovf;
          r_state  <= StClk;
        end
        StClk: begin
          r_ia    <= r_ialpha;
          r_ib    <= w_ib;
          r_ic    <= w_ic;
          r_ovf   <= r_ovf | w_mul_ovf | w_ib_ovf | w_ic_ovf;
          r_state <= StDone;
        end
        StDone: begin
          // First DONE cycle lets the results settle; out_valid follows it.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign ovf       = r_ovf;
  assign ialpha    = r_ialpha;
  assign ibeta     = r_ibeta;
  assign ia        = r_ia;
  assign ib        = r_ib;
  assign ic        = r_ic;

endmodule

// File: tb/tb_park_clark_sequencer.sv
// Scoreboard bench for park_clark_sequencer: accepted inputs are pushed through a
// longint reference model into a queue; a negedge monitor compares presented outputs.
module tb_park_clark_sequencer;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;
  localparam longint KQ   = 64'sd227023;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [31:0] id = '0, iq = '0, ctheta = '0, stheta = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] ialpha, ibeta, ia, ib, ic;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               ovf;

  typedef struct {
    longint ialpha, ibeta, ia, ib, ic;
    longint ovf;
    int     acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   n_acc    = 0;
  int   last_acc = -1;
  bit   b2b      = 1'b0;
  bit   seen     = 1'b0;
  bit   ready_next = 1'b0;
  bit   rand_done  = 1'b0;

  park_clark_sequencer #(.N(32), .Q(18)) dut (
    .clk       (clk),
    .rst       (rst),
    .id        (id),
    .iq        (iq),
    .ctheta    (ctheta),
    .stheta    (stheta),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ialpha    (ialpha),
    .ibeta     (ibeta),
    .ia        (ia),
    .ib        (ib),
    .ic        (ic),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference pieces: Q18 product and N-bit range reduction of a sum.
  function automatic longint qm(input longint a, input longint b, output bit o);
    longint p;
    p = (a * b) >>> 18;
    o = (p > MAXV) || (p < MINV);
    return longint'($signed(p[31:0]));
  endfunction

  function automatic longint fit(input longint x, output bit o);
    o = (x > MAXV) || (x < MINV);
`ifdef PARK_CLARK_SAT_EN
    if (x > MAXV) return MAXV;
    if (x < MINV) return MINV;
    return x;
`else
    return longint'($signed(x[31:0]));
`endif
  endfunction

  function automatic exp_t model(input longint d, input longint q, input longint c,
                                 input longint s);
    exp_t e;
    bit   o0, o1, o2, o3, oa, ob, ok, oib, oic;
    longint p0, p1, p2, p3, kb, half;
    p0 = qm(c, d, o0);
    p1 = qm(s, q, o1);
    p2 = qm(s, d, o2);
    p3 = qm(c, q, o3);
    e.ialpha = fit(p0 - p1, oa);
    e.ibeta  = fit(p2 + p3, ob);
    kb       = qm(KQ, e.ibeta, ok);
    half     = e.ialpha >>> 1;
    e.ia     = e.ialpha;
    e.ib     = fit(kb - half, oib);
    e.ic     = fit(-kb - half, oic);
    e.ovf    = longint'(o0 | o1 | o2 | o3 | oa | ob | ok | oib | oic);
    e.acc_cyc = 0;
    return e;
  endfunction

  // Acceptance observer: counts edges, feeds the scoreboard, checks back-to-back spacing.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (!rst && in_valid && in_ready) begin
      e = model(longint'(id), longint'(iq), longint'(ctheta), longint'(stheta));
      e.acc_cyc = cyc;
      sb.push_back(e);
      n_acc++;
      if (b2b && last_acc >= 0) chk("b2b_spacing", longint'(cyc - last_acc), 9);
      last_acc = cyc;
    end
  end

  // Output monitor: compares every presented cycle, so held outputs must stay put.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      seen       = 1'b0;
      ready_next = 1'b0;
    end else begin
      if (ready_next) begin
        chk("in_ready_after_handshake", longint'(in_ready), 1);
        ready_next = 1'b0;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", longint'(out_valid), 0);
        end else begin
          e = sb[0];
          // Cycle 1 is the one that begins at the accepting edge.
          if (!seen) begin
            seen = 1'b1;
            chk("latency_cycles", longint'(cyc - e.acc_cyc + 1), 8);
          end
          chk("ialpha", longint'(ialpha), e.ialpha);
          chk("ibeta", longint'(ibeta), e.ibeta);
          chk("ia", longint'(ia), e.ia);
          chk("ib", longint'(ib), e.ib);
          chk("ic", longint'(ic), e.ic);
          chk("ovf", longint'(ovf), e.ovf);
          chk("in_ready_busy", longint'(in_ready), 0);
          if (out_ready) begin
            void'(sb.pop_front());
            seen       = 1'b0;
            ready_next = 1'b1;
          end
        end
      end
    end
  end

  task automatic send(input logic signed [31:0] a_id, input logic signed [31:0] a_iq,
                      input logic signed [31:0] a_ct, input logic signed [31:0] a_st);
    int t;
    @(negedge clk);
    id = a_id; iq = a_iq; ctheta = a_ct; stheta = a_st;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", longint'(in_ready), 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || !in_ready) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue", longint'(sb.size()), 0);
  endtask

  function automatic logic signed [31:0] rnd_trig();
    return 32'($signed($urandom_range(0, 524288)) - 262144);
  endfunction

  initial begin
    int t;
    int prev;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_ialpha", longint'(ialpha), 0);
    chk("rst_ic", longint'(ic), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", longint'(in_ready), 1);

    // Directed: unit cosine, then pure iq, then overflow
    send(32'sd262144, 32'sd0, 32'sd262144, 32'sd0);
    drain();
    send(32'sd0, 32'sd262144, 32'sd262144, 32'sd0);
    drain();
    send(32'sd1073741824, 32'sd1073741824, 32'sd262144, -32'sd262144);
    drain();

    // Backpressure: hold out_ready low five cycles while in_valid pulses with junk
    out_ready = 1'b0;
    send(32'sd131072, -32'sd65536, 32'sd200000, 32'sd170000);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp_out_valid_seen", longint'(out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      id = $urandom; iq = $urandom; ctheta = rnd_trig(); stheta = rnd_trig();
      chk("bp_in_ready_low", longint'(in_ready), 0);
      chk("bp_out_valid_held", longint'(out_valid), 1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset while the sequencer is in P2
    send(32'sd300000, 32'sd100000, 32'sd150000, -32'sd90000);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_in_ready", longint'(in_ready), 0);
    chk("midrst_ialpha", longint'(ialpha), 0);
    chk("midrst_ia", longint'(ia), 0);
    chk("midrst_ib", longint'(ib), 0);
    chk("midrst_ovf", longint'(ovf), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready_after", longint'(in_ready), 1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("midrst_no_out_valid", longint'(out_valid), 0);
    end

    // Random traffic with random output backpressure
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          if (k % 2 == 0) send($urandom, $urandom, rnd_trig(), rnd_trig());
          else send(32'($signed($urandom_range(0, 2000000)) - 1000000),
                    32'($signed($urandom_range(0, 2000000)) - 1000000),
                    rnd_trig(), rnd_trig());
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Back-to-back: in_valid and out_ready held high
    b2b      = 1'b1;
    last_acc = -1;
    @(negedge clk);
    id = $urandom; iq = $urandom; ctheta = rnd_trig(); stheta = rnd_trig();
    in_valid = 1'b1;
    prev = n_acc;
    t = 0;
    while (n_acc - prev < 6 && t < 200) begin
      @(negedge clk);
      t++;
      if (n_acc != prev + 0 && n_acc != last_acc) begin
        id = 32'($signed($urandom_range(0, 4000000)) - 2000000);
        iq = 32'($signed($urandom_range(0, 4000000)) - 2000000);
        ctheta = rnd_trig();
        stheta = rnd_trig();
      end
    end
    chk("b2b_accept_count", longint'(n_acc - prev), 6);
    in_valid = 1'b0;
    drain();
    b2b = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
